// File: rtl/isa_consts.sv
// rtl/isa_consts.sv - shared ISA constants, IF/ID queue entry type and HALT decode helper
package isa_consts;

    localparam logic [15:0] NOP_INSTR   = 16'h0800;
    localparam logic [4:0]  HALT_OPCODE = 5'b00000;
    localparam int          IFQ_DEPTH   = 2;
    localparam int          IFQ_ENTRY_W = 48;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pc_2;
    } ifq_entry_t;

    function automatic logic is_halt(input logic [15:0] instr);
        return instr[15:11] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/ifq_entry.sv
// rtl/ifq_entry.sv - one 48-bit queue slot register with write enable
// Ports: clk, rst (async active-high), we (load d), d/q 48-bit slot contents.
module ifq_entry
    import isa_consts::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [IFQ_ENTRY_W-1:0] d,
    output logic [IFQ_ENTRY_W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - two-entry fetch-to-decode queue with HALT stop, flush and overflow error
// Ports: clk, rst (async active-high); fetch side instruction/curr_PC/PC_2_in/fetch_valid,
// fetch_enable back-pressure; decode side decode_ready, instr_out/PC_out/PC_2_out/valid_out;
// flush, halted (sticky), err (push attempted while blocked).
// Optional: IFQ_PERF_CNT_EN adds stall_cnt and flush_cnt saturating counters.
module if_id_queue
    import isa_consts::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instruction,
    input  logic [15:0] curr_PC,
    input  logic [15:0] PC_2_in,
    input  logic        fetch_valid,
    input  logic        decode_ready,
    input  logic        flush,
    output logic        fetch_enable,
    output logic [15:0] instr_out,
    output logic [15:0] PC_out,
    output logic [15:0] PC_2_out,
    output logic        valid_out,
    output logic        halted,
`ifdef IFQ_PERF_CNT_EN
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
`endif
    output logic        err
);

    logic [1:0]  count;
    logic        wr_ptr;
    logic        rd_ptr;
    logic        push;
    logic        pop;
    ifq_entry_t  wr_entry;
    ifq_entry_t  head;
    logic [IFQ_ENTRY_W-1:0] slot_q [IFQ_DEPTH];

    // fetch_enable depends on registered state only, so fetch never sees a
    // combinational path from decode_ready or flush.
    assign fetch_enable = (count < 2'(IFQ_DEPTH)) && !halted;
    assign valid_out    = (count != 2'd0);
    assign err          = fetch_valid && !fetch_enable;

    // flush wins over both push and pop.
    assign push = fetch_valid && fetch_enable && !flush;
    assign pop  = decode_ready && valid_out && !flush;

    assign wr_entry = '{instr: instruction, pc: curr_PC, pc_2: PC_2_in};

    for (genvar i = 0; i < IFQ_DEPTH; i++) begin : g_slot
        ifq_entry u_entry (
            .clk (clk),
            .rst (rst),
            .we  (push && (wr_ptr == 1'(i))),
            .d   (wr_entry),
            .q   (slot_q[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            halted <= 1'b0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            halted <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (push && is_halt(instruction)) begin
                halted <= 1'b1;
            end
        end
    end

    // Empty queue presents a NOP so decode can run freely without gating.
    always_comb begin
        head = ifq_entry_t'(slot_q[rd_ptr]);
        if (valid_out) begin
            instr_out = head.instr;
            PC_out    = head.pc;
            PC_2_out  = head.pc_2;
        end else begin
            instr_out = NOP_INSTR;
            PC_out    = 16'h0000;
            PC_2_out  = 16'h0000;
        end
    end

`ifdef IFQ_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'h0000;
            flush_cnt <= 16'h0000;
        end else begin
            if (!fetch_enable && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush && valid_out && flush_cnt != 16'hFFFF) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - randomized self-checking bench for if_id_queue against a queue model
module tb_if_id_queue;

    logic        clk;
    logic        rst;
    logic [15:0] instruction;
    logic [15:0] curr_PC;
    logic [15:0] PC_2_in;
    logic        fetch_valid;
    logic        decode_ready;
    logic        flush;
    logic        fetch_enable;
    logic [15:0] instr_out;
    logic [15:0] PC_out;
    logic [15:0] PC_2_out;
    logic        valid_out;
    logic        halted;
    logic        err;
`ifdef IFQ_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    int          m_stall;
    int          m_flush;
`endif

    int n_checks;
    int n_errors;

    logic [47:0] m_q[$];
    logic        m_halted;

    if_id_queue dut (
        .clk          (clk),
        .rst          (rst),
        .instruction  (instruction),
        .curr_PC      (curr_PC),
        .PC_2_in      (PC_2_in),
        .fetch_valid  (fetch_valid),
        .decode_ready (decode_ready),
        .flush        (flush),
        .fetch_enable (fetch_enable),
        .instr_out    (instr_out),
        .PC_out       (PC_out),
        .PC_2_out     (PC_2_out),
        .valid_out    (valid_out),
        .halted       (halted),
`ifdef IFQ_PERF_CNT_EN
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
`endif
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_fe();
        return (m_q.size() < 2) && !m_halted;
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_halted = 1'b0;
`ifdef IFQ_PERF_CNT_EN
        m_stall = 0;
        m_flush = 0;
`endif
    endtask

    task automatic check_outputs(input string ctx);
        chk({ctx, ".fetch_enable"}, 32'(fetch_enable), 32'(m_fe()));
        chk({ctx, ".err"}, 32'(err), 32'(fetch_valid && !m_fe()));
        chk({ctx, ".valid_out"}, 32'(valid_out), 32'(m_q.size() != 0));
        chk({ctx, ".halted"}, 32'(halted), 32'(m_halted));
        if (m_q.size() != 0) begin
            chk({ctx, ".instr_out"}, 32'(instr_out), 32'(m_q[0][47:32]));
            chk({ctx, ".PC_out"}, 32'(PC_out), 32'(m_q[0][31:16]));
            chk({ctx, ".PC_2_out"}, 32'(PC_2_out), 32'(m_q[0][15:0]));
        end else begin
            chk({ctx, ".instr_out"}, 32'(instr_out), 32'h0800);
            chk({ctx, ".PC_out"}, 32'(PC_out), 32'h0);
            chk({ctx, ".PC_2_out"}, 32'(PC_2_out), 32'h0);
        end
`ifdef IFQ_PERF_CNT_EN
        chk({ctx, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
        chk({ctx, ".flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
`endif
    endtask

    // Next-state of the abstract queue for the inputs applied this cycle.
    task automatic m_advance();
        logic fe;
        fe = m_fe();
`ifdef IFQ_PERF_CNT_EN
        if (!fe && m_stall < 16'hFFFF) m_stall++;
        if (flush && m_q.size() != 0 && m_flush < 16'hFFFF) m_flush++;
`endif
        if (flush) begin
            m_q.delete();
            m_halted = 1'b0;
        end else begin
            if (decode_ready && m_q.size() != 0) void'(m_q.pop_front());
            if (fetch_valid && fe) begin
                m_q.push_back({instruction, curr_PC, PC_2_in});
                if (instruction[15:11] == 5'b00000) m_halted = 1'b1;
            end
        end
    endtask

    task automatic cycle(input string ctx, input logic fv, input logic [15:0] ins,
                         input logic [15:0] pc, input logic dr, input logic fl);
        fetch_valid  = fv;
        instruction  = ins;
        curr_PC      = pc;
        PC_2_in      = pc + 16'd2;
        decode_ready = dr;
        flush        = fl;
        @(negedge clk);
        check_outputs(ctx);
        m_advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] pc;
        logic [15:0] ins;
        n_checks = 0;
        n_errors = 0;
        m_reset();
        rst = 1'b1;
        fetch_valid = 1'b0; decode_ready = 1'b0; flush = 1'b0;
        instruction = 16'h0; curr_PC = 16'h0; PC_2_in = 16'h0;

        // Reset values with rst held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill to two entries.
        cycle("fill0", 1'b1, 16'h4123, 16'h0000, 1'b0, 1'b0);
        cycle("fill1", 1'b1, 16'h4456, 16'h0002, 1'b0, 1'b0);
        // Overflow: full, push attempt raises err and is dropped.
        cycle("ovf", 1'b1, 16'h4789, 16'h0004, 1'b0, 1'b0);
        cycle("ovf_after", 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        // Now count 1: simultaneous push and pop.
        cycle("simul", 1'b1, 16'h4AAA, 16'h0006, 1'b1, 1'b0);
        cycle("simul_after", 1'b1, 16'h4BBB, 16'h0008, 1'b0, 1'b0);
        // Full plus push and flush.
        cycle("flush", 1'b1, 16'h4CCC, 16'h000A, 1'b1, 1'b1);
        cycle("flush_after", 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        // HALT then flush releases it.
        cycle("halt", 1'b1, 16'h0000, 16'h0010, 1'b0, 1'b0);
        cycle("halt_blk", 1'b1, 16'h4DDD, 16'h0012, 1'b0, 1'b0);
        cycle("halt_flush", 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        cycle("halt_clear", 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        // Pop of an empty queue must be ignored.
        cycle("pop_empty", 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

        // Randomized traffic.
        pc = 16'h0100;
        for (int i = 0; i < 3000; i++) begin
            ins = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ins[15:11] = 5'b00000;
            else if (ins[15:11] == 5'b00000) ins[15:11] = 5'b00001;
            cycle("rand", 1'($urandom_range(0, 3) != 0), ins, pc,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 11) == 0));
            pc = pc + 16'd2;
        end

        // Async reset mid-transfer.
        flush = 1'b0;
        cycle("pre_rst0", 1'b1, 16'h5111, 16'h0200, 1'b0, 1'b0);
        cycle("pre_rst1", 1'b1, 16'h5222, 16'h0202, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        fetch_valid = 1'b0;
        chk("async_rst.valid_out", 32'(valid_out), 32'h0);
        chk("async_rst.instr_out", 32'(instr_out), 32'h0800);
        chk("async_rst.fetch_enable", 32'(fetch_enable), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle("post_rst0", 1'b1, 16'h5333, 16'h0300, 1'b0, 1'b0);
        cycle("post_rst1", 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        cycle("post_rst2", 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock.
REQ-002 SHALL have ports: rst input 1, asynchronous active-high reset.
REQ-003 SHALL have ports: instruction input 16, fetched instruction word from fetch.
REQ-004 SHALL have ports: curr_PC input 16, address of that instruction.
REQ-005 SHALL have ports: PC_2_in input 16, curr_PC+2 from fetch.
REQ-006 SHALL have ports: fetch_valid input 1, fetch presents a valid word this cycle.
REQ-007 SHALL have ports: decode_ready input 1, decode consumes the head entry this cycle.
REQ-008 SHALL have ports: flush input 1, discard all held and incoming entries (taken branch/jump).
REQ-009 SHALL have ports: fetch_enable output 1, drives fetch PC register write enable.
REQ-010 SHALL have ports: instr_out output 16, head instruction (NOP 16'h0800 when empty).
REQ-011 SHALL have ports: PC_out output 16, head PC.
REQ-012 SHALL have ports: PC_2_out output 16, head PC+2.
REQ-013 SHALL have ports: valid_out output 1, head entry valid.
REQ-014 SHALL have ports: halted output 1, HALT (opcode 5'b00000) enqueued, sticky.
REQ-015 SHALL have ports: err output 1, push attempted while blocked.

Function
REQ-016 SHALL hold 2 entries of {instruction, PC, PC+2}; count 0..2; 1-bit read/write pointers wrap 1->0.
REQ-017 SHALL accept a push when fetch_valid=1 and fetch_enable=1.
REQ-018 SHALL pop when decode_ready=1 and valid_out=1; decode_ready with valid_out=0 SHALL be ignored.
REQ-019 fetch_enable SHALL equal (count<2) and not halted, combinational from state only (no input path).
REQ-020 Push-to-output latency SHALL be 1 cycle; no same-cycle bypass.
REQ-021 Simultaneous push and pop at count 1 SHALL leave count 1 with the new entry behind the head.
REQ-022 Push at count 2 SHALL NOT occur (fetch_enable=0); fetch_valid=1 while fetch_enable=0 SHALL raise err for that cycle and drop the word.
REQ-023 flush SHALL outrank push and pop: next count 0, pointers 0, same-cycle push discarded, halted cleared.
REQ-024 Enqueuing a word with instruction[15:11]=5'b00000 SHALL set halted next cycle; halted SHALL block further pushes until flush or rst.
REQ-025 When valid_out=0, instr_out SHALL be 16'h0800, PC_out and PC_2_out SHALL be 16'h0000.
REQ-026 valid_out SHALL equal (count!=0).

Reset
REQ-027 rst SHALL asynchronously clear count, pointers, halted, entry storage; outputs SHALL read valid_out=0, instr_out=16'h0800, PC_out=0, PC_2_out=0, halted=0, err=0, fetch_enable=1.
REQ-028 rst asserted mid-transfer SHALL discard all entries; first accepted push after deassertion SHALL be the first entry.

Configuration
REQ-029 With IFQ_PERF_CNT_EN defined, SHALL add outputs stall_cnt[15:0] (cycles with fetch_enable=0) and flush_cnt[15:0] (cycles with flush=1 and count!=0), both saturating at 16'hFFFF, cleared by rst.
REQ-030 Without IFQ_PERF_CNT_EN, those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-031 NOP encoding 16'h0800, HALT opcode 5'b00000, depth 2 SHALL live in shared package/include isa_consts.
REQ-032 Entry storage SHALL use one sub-module ifq_entry (48-bit register with write enable, async reset), instantiated twice.

Verification
REQ-033 Reset: rst=1 -> valid_out=0, instr_out=16'h0800, fetch_enable=1.
REQ-034 Fill: push 16'h4123@PC 16'h0000, 16'h4456@PC 16'h0002, decode_ready=0 -> count 2, fetch_enable=0, head 16'h4123/PC_2_out 16'h0002.
REQ-035 Overflow: fetch_valid=1 while full -> err=1 one cycle, contents unchanged.
REQ-036 Simultaneous: count 1, push and pop -> count stays 1, head becomes pushed word next cycle.
REQ-037 Flush: count 2 plus push and flush -> next cycle valid_out=0, instr_out=16'h0800.
REQ-038 Halt: push 16'h0000 -> halted=1, fetch_enable=0; flush -> halted=0, fetch_enable=1.
